// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: sequential carry-less GF(2)[x] divider, one dividend bit per cycle
// Ports: clk/rst (sync, active-high); start requests a division of a (2N bits) by b (N bits);
//        busy is high during the bit-serial phase, done pulses for one cycle when q/r/err are valid,
//        err flags a zero divisor; q (2N bits) and r (N bits) hold the last result until the next done.
module gf2_poly_divider #(
    parameter int N = 283
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r
);
    localparam int W  = 2 * N;
    localparam int KW = $clog2(W);
    localparam int DW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, quo_q, quo_d, q_q, q_d;
    logic [N-1:0]  b_q, b_d, rem_q, rem_d, r_q, r_d;
    logic [DW-1:0] d_q, d_d, msb;
    logic [KW-1:0] k_q, k_d, j;
    logic          err_q, err_d, hit;
    logic [N-1:0]  rem_sh, rem_step;

    // degree of the incoming divisor: the last (highest) set bit wins
    always_comb begin
        msb = '0;
        for (int i = 0; i < N; i++) msb = b[i] ? DW'(i) : msb;
    end

    // dividend bits are consumed MSB first; the working remainder never exceeds degree d
    assign j        = K_LAST - k_q;
    assign rem_sh   = (rem_q << 1) | N'(a_q[j]);
    assign hit      = rem_sh[d_q];
    assign rem_step = hit ? rem_sh ^ b_q : rem_sh;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        k_d     = k_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (start && b == '0) begin
                state_d = DONE;
                err_d   = 1'b1;
                q_d     = '0;
                r_d     = '0;
            end else if (start) begin
                state_d = DIV;
                a_d     = a;
                b_d     = b;
                d_d     = msb;
                rem_d   = '0;
                quo_d   = '0;
                k_d     = '0;
            end
        end else if (state_q == DIV) begin
            rem_d    = rem_step;
            quo_d[j] = hit;
            k_d      = k_q + 1'b1;
            if (k_q == K_LAST) begin
                state_d = DONE;
                q_d     = quo_d;
                r_d     = rem_step;
                err_d   = 1'b0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            k_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            k_q     <= k_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign busy = state_q == DIV;
    assign done = state_q == DONE;
    assign err  = err_q;
    assign q    = q_q;
    assign r    = r_q;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb_gf2_poly_divider: randomized self-checking bench for gf2_poly_divider against a long-division model
module tb_gf2_poly_divider;
    localparam int N = 283;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst, start, busy, done, err;
    logic [W-1:0] a, q;
    logic [N-1:0] b, r;
    int           total = 0;
    int           bad = 0;

    gf2_poly_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .q(q), .r(r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
        return v;
    endfunction

    function automatic logic [N-1:0] rand_nz();
        logic [N-1:0] v;
        do v = N'(rand_w()) >> $urandom_range(0, N - 1); while (v == '0);
        return v;
    endfunction

    function automatic logic [W-1:0] clmul(input logic [W-1:0] x, input logic [N-1:0] y);
        logic [W-1:0] p = '0;
        for (int i = 0; i < N; i++) if (y[i]) p ^= x << i;
        return p;
    endfunction

    // schoolbook polynomial long division over the full 2N-bit dividend
    task automatic model(input logic [W-1:0] av, input logic [N-1:0] bv,
                         output logic [W-1:0] qq, output logic [N-1:0] rr, output logic ee);
        logic [W-1:0] rem = av;
        int d = -1;
        qq = '0;
        rr = '0;
        ee = (bv == '0);
        for (int i = 0; i < N; i++) if (bv[i]) d = i;
        if (d < 0) return;
        for (int i = W - 1; i >= d; i--)
            if (rem[i]) begin
                rem ^= W'(bv) << (i - d);
                qq[i - d] = 1'b1;
            end
        rr = N'(rem);
    endtask

    // called at a negedge; start is sampled on the very next rising edge
    task automatic run(input string tag, input logic [W-1:0] av, input logic [N-1:0] bv,
                       input logic [W-1:0] eq, input logic [N-1:0] er, input logic ee, input int poke);
        logic [W-1:0] q0 = q;
        logic [N-1:0] r0 = r;
        logic e0 = err;
        logic both = 1'b0, busy_seen = 1'b0, moved = 1'b0;
        int cyc = 1;
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = rand_w();
        b = N'(rand_w());
        while (!done && cyc < 2000) begin
            busy_seen |= busy;
            if (q !== q0 || r !== r0 || err !== e0) moved = 1'b1;
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        both = busy & done;
        check({tag, " latency"}, W'(cyc), bv == '0 ? W'(1) : W'(W + 1));
        check({tag, " q"}, q, eq);
        check({tag, " r"}, W'(r), W'(er));
        check({tag, " err"}, W'(err), W'(ee));
        check({tag, " busy_done"}, W'(both), '0);
        check({tag, " busy_seen"}, W'(busy_seen), W'(bv != '0));
        check({tag, " held"}, W'(moved), '0);
        @(negedge clk);
        check({tag, " done_pulse"}, W'(done), '0);
        @(negedge clk);
        check({tag, " no_requeue"}, W'(busy), '0);
    endtask

    task automatic run_model(input string tag, input logic [W-1:0] av, input logic [N-1:0] bv, input int poke);
        logic [W-1:0] eq;
        logic [N-1:0] er;
        logic ee;
        model(av, bv, eq, er, ee);
        run(tag, av, bv, eq, er, ee, poke);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
    endtask

    initial begin
        logic [W-1:0] av, eq;
        logic [N-1:0] bv, x, er;
        logic ee;
        int n;
        rst = 1'b1;
        start = 1'b1;
        a = rand_w();
        b = rand_nz();
        repeat (3) @(negedge clk);
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset err", W'(err), '0);
        check("reset q", q, '0);
        check("reset r", W'(r), '0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run("small", W'(4'b1011), N'(2'b11), W'(3'b110), N'(1), 1'b0, 0);
        run("div0", rand_w(), '0, '0, '0, 1'b1, 0);
        av = rand_w();
        run("ident", av, N'(1), av, '0, 1'b0, 0);
        bv = rand_nz();
        run("self", W'(bv), bv, W'(1), '0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            x = N'(rand_w());
            bv = rand_nz();
            run("roundtrip", clmul(W'(x), bv), bv, W'(x), '0, 1'b0, 0);
        end
        bv = '0;
        bv[282] = 1'b1;
        bv[12] = 1'b1;
        bv[7] = 1'b1;
        bv[5] = 1'b1;
        bv[0] = 1'b1;
        av = W'(1) << 565;
        run_model("modred", av, bv, 0);
        check("modred recompose", clmul(q, bv) ^ W'(r), av);
        bv = N'(rand_w()) | (N'(1) << 282);
        av = W'(N'(rand_w())) & ((W'(1) << 282) - W'(1));
        run("lowdeg", av, bv, '0, N'(av), 1'b0, 0);
        for (int i = 0; i < 4; i++) run_model("random", rand_w(), rand_nz(), 0);
        run_model("poke", rand_w(), rand_nz(), 101);

        a = rand_w();
        b = rand_nz();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", W'(busy), '0);
        check("abort done", W'(done), '0);
        check("abort q", q, '0);
        check("abort r", W'(r), '0);
        check("abort err", W'(err), '0);
        run_model("post_rst", rand_w(), rand_nz(), 0);

        av = rand_w();
        bv = rand_nz();
        model(av, bv, eq, er, ee);
        a = av;
        b = bv;
        start = 1'b1;
        wait_done(n);
        check("hold first", W'(n), W'(W + 1));
        for (int i = 0; i < 2; i++) begin
            wait_done(n);
            check("hold period", W'(n), W'(W + 2));
            check("hold q", q, eq);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold stop", W'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gf2_poly_divider.md
GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

Interface
REQ-001 The block SHALL have one parameter: N, default 283, divisor width in bits; the dividend width is 2N.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 2N bits: dividend polynomial over GF(2), bit i is the coefficient of x^i.
REQ-006 The block SHALL have port b, input, N bits: divisor polynomial over GF(2), same bit ordering.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the block is in DIV.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when q, r and err are valid.
REQ-009 The block SHALL have port err, output, 1 bit: divisor was zero; valid with done.
REQ-010 The block SHALL have port q, output, 2N bits: quotient.
REQ-011 The block SHALL have port r, output, N bits: remainder, with r[N-1] always 0.

Function
REQ-012 The block SHALL compute carry-less (GF(2)[x]) division with a = q·b XOR r, deg r < deg b, and no integer carries.
REQ-013 The block SHALL implement states IDLE, DIV and DONE.
REQ-014 In IDLE with start=1 and b≠0, the block SHALL capture a and b, register d = index of the highest set bit of b, clear the working remainder R (N bits) and the working quotient Q (2N bits), load step counter k=0, and go to DIV.
REQ-015 In IDLE with start=1 and b=0, the block SHALL go to DONE with err=1, q=0 and r=0 on that edge.
REQ-016 In DIV, each cycle SHALL perform one step on dividend bit j=2N-1-k.
REQ-016a Step part 1: R' = {R[N-2:0], a_cap[j]}.
REQ-016b Step part 2: if R'[d]=1, then R = R' XOR b_cap and Q[j]=1; otherwise R = R' and Q[j]=0.
REQ-016c Step part 3: k increments.
REQ-017 After the step with k=2N-1 (exactly 2N DIV cycles, 566 at the default N), the block SHALL go to DONE and load q=Q, r=R and err=0.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be independent of operand values.
REQ-019a For b≠0, done SHALL be high in the cycle following the 2N+1-th rising edge counted from the edge that sampled start.
REQ-019b For b=0, done SHALL be high in the cycle following the edge that sampled start.
REQ-020 q, r and err SHALL hold their last values from DONE until the next DONE; they SHALL NOT change during DIV.
REQ-021 start while in DIV or DONE SHALL be ignored and not queued; a and b changes after capture SHALL NOT affect the result.
REQ-022 busy SHALL be 1 exactly in DIV; done and busy SHALL never both be 1.
REQ-023 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle immediately after DONE.
REQ-024 b=1 (d=0) SHALL give q=a and r=0.
REQ-025 deg a < deg b SHALL give q=0 and r=a[N-1:0].

Reset
REQ-026 With rst=1 on a rising edge, the block SHALL enter IDLE and clear busy, done, err, q, r, R, Q, k and d to 0, overriding start.
REQ-027 rst during DIV or DONE SHALL abort the operation with no done pulse; a start in the cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-028 Small case: a=0b1011 (x^3+x+1), b=0b11 (x+1) -> after 567 cycles done=1, q=0b110, r=0b1, err=0.
REQ-029 Divide by zero: b=0, any a -> done=1 one cycle after start, err=1, q=0, r=0, busy never high.
REQ-030 Identity and self-division:
REQ-030a a=random 566-bit, b=1 -> q=a, r=0.
REQ-030b a=b=random nonzero (zero-extended) -> q=1, r=0.
REQ-031 Round trip: a = carry-less product of random 283-bit x and nonzero y, b=y -> q=x (zero-extended), r=0.
REQ-032 Modular reduction: a=x^565, b=x^283 field polynomial truncated to 283 bits is not representable, so use b=x^282+x^12+x^7+x^5+1 -> r equals a golden-model remainder, and q·b XOR r = a.
REQ-033 Control boundaries:
REQ-033a A start pulse at k=100 -> ignored, result unchanged.
REQ-033b rst asserted at k=300 -> no done, all outputs 0.
REQ-033c start held high continuously -> done pulses every 568 cycles.
